// File: rtl/booth_r8_seq_mult_if.sv
// Operand/product bus for the sequential radix-8 Booth multiplier.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both high. A source holds valid and its payload stable until that edge; a
// sink may raise or drop ready freely, and ready never depends
// combinationally on valid (nor valid on ready).
interface booth_r8_seq_mult_if #(
   parameter int DATA_WIDTH = 16
);
   logic                      in_valid;
   logic                      in_ready;
   logic [DATA_WIDTH-1:0]     a_in;
   logic [DATA_WIDTH-1:0]     b_in;
   logic                      out_valid;
   logic                      out_ready;
   logic [2*DATA_WIDTH-1:0]   product;

   // Producer of operands / consumer of products.
   modport master (
      output in_valid, a_in, b_in, out_ready,
      input  in_ready, out_valid, product
   );

   // The multiplier itself.
   modport slave (
      input  in_valid, a_in, b_in, out_ready,
      output in_ready, out_valid, product
   );
endinterface

// File: rtl/booth_r8_seq_mult.sv
// Sequential signed radix-8 Booth multiplier: one 3-bit Booth group per
// cycle through a combinational digit decoder, accumulated into a wide
// register that also serves as the registered product.

// Radix-8 Booth digit decoder: pp = digit(sel) * a, as a (W+2)-bit value.
module BoothDecode_16b #(
   parameter int W = 16
) (
   input  logic [W-1:0] a,
   input  logic [3:0]   sel,
   output logic [W+1:0] pp
);
   logic [W+1:0] a_x;
   logic [W+1:0] a_x3;

   assign a_x  = (W+2)'($signed(a));
   assign a_x3 = a_x + (a_x << 1);

   // Map the 4-bit window to a digit in -4..+4 and scale the multiplicand.
   always_comb begin
      pp = '0;
      unique case (sel)
         4'd0, 4'd15:  pp = '0;
         4'd1, 4'd2:   pp = a_x;
         4'd3, 4'd4:   pp = a_x << 1;
         4'd5, 4'd6:   pp = a_x3;
         4'd7:         pp = a_x << 2;
         4'd8:         pp = -(a_x << 2);
         4'd9, 4'd10:  pp = -a_x3;
         4'd11, 4'd12: pp = -(a_x << 1);
         default:      pp = -a_x;
      endcase
   end
endmodule

module booth_r8_seq_mult #(
   parameter int DATA_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   booth_r8_seq_mult_if.slave     bus,
   output logic [1:0]             dbg_state,
   output logic [3:0]             dbg_sel
);
   localparam int NUM_GROUPS = (DATA_WIDTH + 2) / 3;
   localparam int BW         = 3 * NUM_GROUPS;
   localparam int PP_W       = DATA_WIDTH + 2;
   localparam int ACC_W      = BW + DATA_WIDTH + 2;
   localparam int CNT_W      = $clog2(NUM_GROUPS);
   localparam int SH_W       = $clog2(ACC_W);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] a_q, a_d;
   logic [BW-1:0]         b_q, b_d;
   logic [ACC_W-1:0]      acc_q, acc_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;

   logic [BW:0]           b_ext;
   logic [SH_W-1:0]       shamt;
   logic [3:0]            sel;
   logic [PP_W-1:0]       pp;
   logic                  digit_neg;
   logic                  pp_sign;
   logic [ACC_W-1:0]      pp_ext;

   // Booth window for the current group; b_ext bit 0 is the implicit b[-1]=0.
   always_comb begin
      b_ext = {b_q, 1'b0};
      shamt = SH_W'(cnt_q) + SH_W'(cnt_q) + SH_W'(cnt_q);
      sel   = 4'(b_ext >> shamt);
   end

   BoothDecode_16b #(.W(DATA_WIDTH)) u_dec (
      .a   (a_q),
      .sel (sel),
      .pp  (pp)
   );

   // The (W+2)-bit pp cannot hold +2^(W+1) (digit -4 times the most negative
   // multiplicand), so the extension bit comes from the operand signs instead
   // of pp's own MSB; this keeps every product exact.
   always_comb begin
      digit_neg = sel[3] && (sel != 4'hF);
      pp_sign   = (pp != '0) && (digit_neg ^ a_q[DATA_WIDTH-1]);
      pp_ext    = ACC_W'($signed({pp_sign, pp}));
   end

   // Next-state, datapath updates and handshake outputs.
   always_comb begin
      state_d       = state_q;
      a_d           = a_q;
      b_d           = b_q;
      acc_d         = acc_q;
      cnt_d         = cnt_q;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      unique case (state_q)
         IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
               a_d     = bus.a_in;
               b_d     = BW'($signed(bus.b_in));
               acc_d   = '0;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            acc_d = acc_q + (pp_ext << shamt);
            if (cnt_q == CNT_W'(NUM_GROUPS - 1)) begin
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.product = acc_q[2*DATA_WIDTH-1:0];
   assign dbg_state   = state_q;
   assign dbg_sel     = sel;
endmodule

// File: tb/tb_booth_r8_seq_mult.sv
// Bench for booth_r8_seq_mult: directed corner products, backpressure,
// operand isolation, mid-run reset and a long random streaming run.
module tb_booth_r8_seq_mult;
   localparam int W  = 16;
   localparam int NG = (W + 2) / 3;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   booth_r8_seq_mult_if #(.DATA_WIDTH(W)) bus ();
   logic [1:0] dbg_state;
   logic [3:0] dbg_sel;

   booth_r8_seq_mult #(.DATA_WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .dbg_state (dbg_state),
      .dbg_sel   (dbg_sel)
   );

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", tag, $time, obs, exp);
      end
   endtask

   function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
      logic signed [2*W-1:0] p;
      p = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
      return p;
   endfunction

   // ---------------- scoreboard ----------------
   logic [2*W-1:0] exp_q[$];
   bit             spacing_en = 1'b0;
   int             last_out   = -1;
   bit             sel_seen[16];

   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
      end else begin
         if (bus.in_valid && bus.in_ready)
            exp_q.push_back(model(bus.a_in, bus.b_in));
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0)
               check("sb_unexpected_output", 1, 0);
            else
               check("sb_product", bus.product, exp_q.pop_front());
            if (spacing_en) begin
               if (last_out >= 0)
                  check("spacing", cyc - last_out, NG + 2);
               last_out = cyc;
            end
         end
         if (dbg_state == 2'd1)
            sel_seen[dbg_sel] = 1'b1;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!bus.in_ready && n < 20) begin
         step();
         n++;
      end
      if (!bus.in_ready) check("in_ready_timeout", 0, 1);
   endtask

   // One transaction; latency counts edges after the accept edge until
   // out_valid (accept cycle t, first out_valid in cycle t+NG+1).
   task automatic run_one(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] exp, input int hold);
      int n;
      wait_ready();
      bus.a_in      = a;
      bus.b_in      = b;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b0;
      step();
      bus.in_valid = 1'b0;
      n = 0;
      while (!bus.out_valid && n < 20) begin
         bus.a_in = W'($urandom);
         bus.b_in = W'($urandom);
         step();
         n++;
      end
      check("latency", n, NG);
      check("product", bus.product, exp);
      for (int i = 0; i < hold; i++) begin
         bus.in_valid = 1'b1;
         bus.a_in     = W'($urandom);
         bus.b_in     = W'($urandom);
         step();
         check("bp_out_valid", bus.out_valid, 1);
         check("bp_product", bus.product, exp);
         check("bp_in_ready", bus.in_ready, 0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      check("back_to_idle", dbg_state, 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n;
      int cov;
      logic [W-1:0] a, b;
      logic [W-1:0] corner[4];
      corner[0] = 16'h8000; corner[1] = 16'h7FFF;
      corner[2] = 16'h0000; corner[3] = 16'hFFFF;

      rst = 1'b1;
      bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      bus.a_in = '0; bus.b_in = '0;
      repeat (3) step();
      check("rst_state", dbg_state, 0);
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_product", bus.product, 0);
      rst = 1'b0;
      step();

      run_one(16'd3,    16'd5,    32'd15,         5);
      run_one(16'h8000, 16'h8000, 32'h40000000,   0);
      run_one(16'h7FFF, 16'h8000, 32'hC0008000,   0);
      run_one(16'h7FFF, 16'h7FFF, 32'h3FFF0001,   0);
      run_one(16'hFFFF, 16'hFFFF, 32'h00000001,   0);
      run_one(16'h8000, 16'h0800, 32'hFC000000,   0);
      run_one(16'h8000, 16'h7FFF, 32'hC0008000,   2);

      // Reset during the third RUN cycle aborts the operation.
      wait_ready();
      bus.a_in = 16'h1234; bus.b_in = 16'h0567; bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("midrst_state", dbg_state, 0);
      check("midrst_in_ready", bus.in_ready, 1);
      check("midrst_out_valid", bus.out_valid, 0);
      check("midrst_product", bus.product, 0);
      run_one(16'd7, 16'hFFF7, 32'hFFFFFFC1, 0);

      // Streaming: in_valid and out_ready held high.
      last_out      = -1;
      spacing_en    = 1'b1;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         a = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom_range(0, 65535));
         b = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom_range(0, 65535));
         bus.a_in     = a;
         bus.b_in     = b;
         bus.in_valid = 1'b1;
         wait_ready();
         step();
      end
      bus.in_valid = 1'b0;
      n = 0;
      while (exp_q.size() != 0 && n < 40) begin
         step();
         n++;
      end
      spacing_en = 1'b0;
      check("drain_queue", exp_q.size(), 0);

      cov = 0;
      for (int s = 0; s < 16; s++) if (sel_seen[s]) cov++;
      check("sel_coverage", cov, 16);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/booth_r8_seq_mult.md
# booth_r8_seq_mult

Sequential signed radix-8 Booth multiplier built around `BoothDecode_16b`. It sits directly upstream of the decoder and consumes its output:
- **Upstream role:** scans the multiplier operand and produces the 4-bit Booth window `sel` once per cycle.
- **Downstream role:** accumulates the returned 18-bit partial products, shifted by 3 bits per group, into a full-width product.

Operands enter and the product leaves over valid/ready handshakes. This is the area-lean multiplier option for the NTT datapath.

## Interface
- `DATA_WIDTH`, default 16: operand width. Must be ≥ 4.
- `NUM_GROUPS`, default ceil(`DATA_WIDTH`/3) = 6: Booth groups. This is a derived localparam and must not be overridden.
- `clk` input, 1: the single clock. All state updates on its rising edge.
- `rst` input, 1: synchronous, active-high reset.
- `in_valid` input, 1: an operand pair is presented.
- `in_ready` output, 1: the block can accept operands.
- `a_in` input, `DATA_WIDTH`: multiplicand, signed two's complement.
- `b_in` input, `DATA_WIDTH`: multiplier, signed two's complement.
- `out_valid` output, 1: `product` is valid.
- `out_ready` input, 1: the consumer accepts `product`.
- `product` output, 2·`DATA_WIDTH`: signed `a_in`·`b_in`.

## Operation
- **FSM states:** IDLE, RUN, DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`:
    - capture `a_in` into `a_q`;
    - capture `b_in`, sign-extended to 3·`NUM_GROUPS` bits, into `b_q`;
    - clear the accumulator;
    - set `cnt`=0;
    - go to RUN.
- **RUN**
  - `in_ready`=0.
  - Window for group `cnt`: `sel` = {`b_q`[3cnt+2], `b_q`[3cnt+1], `b_q`[3cnt], `b_q`[3cnt−1]}, with `b_q`[−1]=0.
  - Decoder mapping of `sel` to digit:
    - 0 and 15 → 0
    - 1 and 2 → +1
    - 3 and 4 → +2
    - 5 and 6 → +3
    - 7 → +4
    - 8 → −4
    - 9 and 10 → −3
    - 11 and 12 → −2
    - 13 and 14 → −1
  - The instantiated `BoothDecode_16b` returns `pp` = digit·`a_q` as an 18-bit signed value.
  - Each cycle, `acc` += sign-extend(`pp`) << 3·`cnt`.
  - `acc` is 3·`NUM_GROUPS`+`DATA_WIDTH`+2 bits wide, so no overflow occurs.
  - When `cnt`=`NUM_GROUPS`−1, go to DONE. Otherwise increment `cnt`.
- **DONE**
  - `out_valid`=1.
  - `product` = `acc`[2·`DATA_WIDTH`−1:0]. The result is exact for every signed input pair, including −2^(W−1)·−2^(W−1).
  - On `out_ready`=1, go to IDLE.
- **Operand isolation:** `a_in` and `b_in` are ignored outside the IDLE accept cycle. Changing them during RUN or DONE has no effect.
- **No overlap:** a new operand pair is accepted only in IDLE. A pair presented in DONE waits.

## Timing
- **Reset values:** state=IDLE, `in_ready`=1, `out_valid`=0, `product`=0, `acc`=0, `cnt`=0.
- **Reset mid-RUN or mid-DONE:** the operation is aborted with no output. The next cycle sees the reset values, and a pending product is lost.
- **Latency:** accept edge at cycle t; RUN during cycles t+1 … t+`NUM_GROUPS`; `out_valid` first high at t+`NUM_GROUPS`+1 (t+7 for the default).
- **Throughput:** with `out_ready` held at 1, one product per `NUM_GROUPS`+2 cycles (8 for the default).
  - Back-to-back: `out_ready` and `in_valid` both high in DONE. The block returns to IDLE, and the new accept happens on the following cycle.
- **Backpressure:** while `out_valid`=1 and `out_ready`=0, `product` and `out_valid` hold stable indefinitely.
- **Output path:** `product` is registered.
- **Decoder path:** the decoder is combinational between `a_q`/`cnt` and the accumulator adder. That one-cycle path is the critical path.
- **Handshake rules:** `in_ready` depends only on state, never combinationally on `in_valid`. `out_valid` never depends on `out_ready`.

## Test plan
- **Basic product:** `a_in`=3, `b_in`=5, accepted at cycle 0 → `out_valid` rises at cycle 7, `product`=15. The product stays 15 until `out_ready`=1.
- **Extremes:**
  - 0x8000·0x8000 → 0x40000000
  - 0x7FFF·0x8000 → 0xC0008000
  - 0x7FFF·0x7FFF → 0x3FFF0001
  - −1·−1 → 1
- **Backpressure and operand isolation:** hold `out_ready`=0 for 5 cycles after `out_valid`. `product` and `out_valid` must stay stable, and `in_ready` must stay 0. Toggle `a_in` and `b_in` during RUN; the result must be unchanged.
- **Mid-run reset:** assert `rst` for 1 cycle at RUN cycle 3 → the next cycle shows IDLE with `in_ready`=1, `out_valid`=0, `product`=0. A new pair 7·−9 then yields −63 (0xFFFFFFC1).
- **Streaming:** `in_valid` and `out_ready` tied high for 1000 random pairs. Results must match the signed reference model with exactly 8-cycle spacing.
- **Sel coverage:** confirm all 16 `sel` codes reach the decoder across the random run, each with the correct accumulated contribution.
